// File: rtl/sqrt_feeder_pkg.sv
// Shared definitions for the square-root feeder: FSM encoding and parameter defaults.
// The issue path walks IDLE -> ACK -> RUN -> HOLD once per operand.
package sqrt_feeder_pkg;

  localparam int DEPTH_DEFAULT       = 4;
  localparam int ACK_TIMEOUT_DEFAULT = 4;
  localparam int DATA_W              = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Next pointer value for a power-of-two ring; wraps by truncation.
  function automatic logic [3:0] ptr_next(input logic [3:0] ptr);
    return ptr + 4'd1;
  endfunction

endpackage

// File: rtl/sqrt_feeder_fifo.sv
// Operand FIFO: power-of-two ring buffer with an occupancy counter.
// The head entry is read combinationally; a pushed entry is visible from the next cycle.
module sqrt_feeder_fifo
  import sqrt_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = DATA_W,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;
  logic [3:0]    wr_ptr_ext;
  logic [3:0]    rd_ptr_ext;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == {LW{1'b0}});
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  assign wr_ptr_ext = 4'(wr_ptr);
  assign rd_ptr_ext = 4'(rd_ptr);

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      level  <= {LW{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= AW'(ptr_next(wr_ptr_ext));
      end
      if (pop_ok) begin
        rd_ptr <= AW'(ptr_next(rd_ptr_ext));
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sqrt_feeder.sv
// Feeds queued operands one at a time to a square-root unit and holds each root
// until the consumer takes it; a missing busy acknowledge drops the operand and flags err_o.
module sqrt_feeder
  import sqrt_feeder_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               x_bi,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [7:0]               sr_x_bo,
  output logic                     sr_start_o,
  input  logic                     sr_busy_i,
  input  logic [7:0]               sr_y_bi,
  output logic [7:0]               y_bo,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     err_o
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] ack_cnt;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          fifo_push;

  assign ready_o   = !fifo_full;
  assign fifo_push = valid_i;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !sr_busy_i;

  sqrt_feeder_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .din   (x_bi),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .level (level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // HOLD spends its first cycle raising valid_o so the captured root is never offered early.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      ack_cnt    <= {CW{1'b0}};
      sr_x_bo    <= 8'd0;
      sr_start_o <= 1'b0;
      y_bo       <= 8'd0;
      valid_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      sr_start_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            sr_x_bo    <= fifo_head;
            sr_start_o <= 1'b1;
            ack_cnt    <= {CW{1'b0}};
            state      <= ST_ACK;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACK: begin
          if (sr_busy_i) begin
            state <= ST_RUN;
          end else if (ack_cnt == ACK_LAST) begin
            err_o <= 1'b1;
            state <= ST_IDLE;
          end else begin
            ack_cnt <= ack_cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (!sr_busy_i) begin
            y_bo  <= sr_y_bi;
            state <= ST_HOLD;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_HOLD: begin
          if (!valid_o) begin
            valid_o <= 1'b1;
          end else if (ready_i) begin
            valid_o <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            state <= ST_HOLD;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_feeder.sv
// Self-checking bench for sqrt_feeder driving a small iterative square-root unit.
// Expected operands/roots are queued at push time and checked as the DUT issues and returns them.
module tb_sqrt_feeder;

  localparam int DEPTH = 4;
  localparam int ACK_TIMEOUT = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] x_bi = 8'd0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] sr_x_bo;
  logic       sr_start_o;
  logic       sr_busy_i;
  logic [7:0] sr_y_bi;
  logic [7:0] y_bo;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [$clog2(DEPTH):0] level_o;
  logic       err_o;

  int total = 0;
  int bad = 0;

  sqrt_feeder #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .x_bi       (x_bi),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sr_x_bo    (sr_x_bo),
    .sr_start_o (sr_start_o),
    .sr_busy_i  (sr_busy_i),
    .sr_y_bi    (sr_y_bi),
    .y_bo       (y_bo),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Square-root unit: one result bit per cycle, then lat extra busy cycles.
  int         lat = 2;
  logic       kill = 1'b0;
  logic       u_busy;
  logic [7:0] u_op;
  logic [3:0] u_root;
  logic [3:0] u_trial;
  logic [7:0] u_sq;
  int         u_step;
  int         u_wait;

  assign u_trial   = u_root | (4'b0001 << u_step);
  assign u_sq      = {4'b0000, u_trial} * {4'b0000, u_trial};
  assign sr_busy_i = u_busy;
  assign sr_y_bi   = {4'b0000, u_root};

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      u_busy <= 1'b0;
      u_op   <= 8'd0;
      u_root <= 4'd0;
      u_step <= 0;
      u_wait <= 0;
    end else if (!u_busy) begin
      if (sr_start_o && !kill) begin
        u_busy <= 1'b1;
        u_op   <= sr_x_bo;
        u_root <= 4'd0;
        u_step <= 3;
        u_wait <= lat;
      end
    end else if (u_step >= 0) begin
      if (u_sq <= u_op) u_root <= u_trial;
      u_step <= u_step - 1;
    end else if (u_wait > 0) begin
      u_wait <= u_wait - 1;
    end else begin
      u_busy <= 1'b0;
    end
  end

  logic [7:0] xq[$];
  logic [7:0] yq[$];
  int cyc = 0;
  int start_count = 0;
  int res_count = 0;
  int valid_cycles = 0;
  int lvl_peak = 0;
  int last_start_cyc = 0;
  int fall_cyc = 0;
  logic busy_prev = 1'b0;
  logic valid_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        busy_prev = 1'b0;
        valid_prev = 1'b0;
      end else begin
        cyc++;
        if (int'(level_o) > lvl_peak) lvl_peak = int'(level_o);
        if (sr_start_o) begin
          start_count++;
          last_start_cyc = cyc;
          chk("start_expected", int'(xq.size() > 0), 1);
          if (xq.size() > 0) chk("sr_x_bo", int'(sr_x_bo), int'(xq.pop_front()));
        end
        if (busy_prev && !sr_busy_i) fall_cyc = cyc;
        if (valid_o && !valid_prev) chk("valid_after_busy_fall", cyc - fall_cyc, 2);
        if (valid_o) valid_cycles++;
        if (valid_o && ready_i) begin
          res_count++;
          chk("result_expected", int'(yq.size() > 0), 1);
          if (yq.size() > 0) chk("y_bo", int'(y_bo), int'(yq.pop_front()));
        end
        busy_prev = sr_busy_i;
        valid_prev = valid_o;
      end
    end
  end

  task automatic push_op(input logic [7:0] x, input logic [7:0] r);
    int n;
    n = 0;
    valid_i = 1'b1;
    x_bi = x;
    @(negedge clk_i);
    while (!ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("push_accepted", int'(ready_o), 1);
    if (ready_o) begin
      xq.push_back(x);
      yq.push_back(r);
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(xq.size() == 0 && yq.size() == 0 && !valid_o && level_o == 0 && !sr_busy_i) && n < 600) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_drain"}, int'(n < 600), 1);
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] root;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int sc;
    int vc;
    int rc;
    int n;
    logic [7:0] y0;

    vecs[0] = '{8'd1,   8'd1};
    vecs[1] = '{8'd15,  8'd3};
    vecs[2] = '{8'd16,  8'd4};
    vecs[3] = '{8'd200, 8'd14};
    vecs[4] = '{8'd143, 8'd11};
    vecs[5] = '{8'd144, 8'd12};
    vecs[6] = '{8'd80,  8'd8};
    vecs[7] = '{8'd3,   8'd1};
    vecs[8] = '{8'd225, 8'd15};
    vecs[9] = '{8'd48,  8'd6};

    #12;
    chk("rst_level", int'(level_o), 0);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_start", int'(sr_start_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_y", int'(y_bo), 0);
    chk("rst_err", int'(err_o), 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Single operand: one start pulse, one valid cycle.
    ready_i = 1'b1;
    sc = start_count;
    vc = valid_cycles;
    push_op(8'd100, 8'd10);
    wait_idle("single");
    chk("single_starts", start_count - sc, 1);
    chk("single_valid_cycles", valid_cycles - vc, 1);

    // Table of operands pushed back-to-back.
    rc = res_count;
    for (int i = 0; i < 10; i++) begin
      lat = i % 3;
      push_op(vecs[i].x, vecs[i].root);
    end
    wait_idle("table");
    chk("table_results", res_count - rc, 10);
    lat = 2;

    // Stall in HOLD, queue three operands, then hold off acceptance for 10 cycles.
    ready_i = 1'b0;
    sc = start_count;
    push_op(8'd1, 8'd1);
    lvl_peak = 0;
    push_op(8'd0, 8'd0);
    push_op(8'd255, 8'd15);
    push_op(8'd99, 8'd9);
    n = 0;
    while (!valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("hold_valid", int'(valid_o), 1);
    chk("peak_level", lvl_peak, 3);
    y0 = y_bo;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("hold_y_stable", int'(y_bo), int'(y0));
    end
    chk("hold_no_start", start_count - sc, 1);
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("accept_valid_low", int'(valid_o), 0);
    chk("accept_no_start_yet", int'(sr_start_o), 0);
    @(negedge clk_i);
    chk("resume_start", int'(sr_start_o), 1);
    wait_idle("burst");
    chk("burst_starts", start_count - sc, 4);

    // Overfill while issue is stalled behind an unaccepted result.
    ready_i = 1'b0;
    rc = res_count;
    push_op(8'd16, 8'd4);
    push_op(8'd200, 8'd14);
    push_op(8'd143, 8'd11);
    push_op(8'd144, 8'd12);
    push_op(8'd80, 8'd8);
    chk("full_level", int'(level_o), 4);
    chk("full_ready_low", int'(ready_o), 0);
    fork
      push_op(8'd15, 8'd3);
      begin
        repeat (5) @(negedge clk_i);
        chk("full_held", int'(level_o), 4);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
      end
    join
    wait_idle("overfill");
    chk("overfill_results", res_count - rc, 6);

    // Busy never rises: timeout, drop, issue next.
    kill = 1'b1;
    push_op(8'd49, 8'd7);
    push_op(8'd121, 8'd11);
    n = 0;
    while (!err_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("err_set", int'(err_o), 1);
    chk("err_delay", cyc - last_start_cyc, ACK_TIMEOUT);
    kill = 1'b0;
    if (yq.size() > 0) void'(yq.pop_front());
    wait_idle("timeout");
    chk("err_sticky", int'(err_o), 1);

    // Reset while RUN with two operands queued.
    push_op(8'd144, 8'd12);
    push_op(8'd16, 8'd4);
    push_op(8'd200, 8'd14);
    n = 0;
    while (!sr_busy_i && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("pre_rst_level", int'(level_o), 2);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_level", int'(level_o), 0);
    chk("mid_rst_ready", int'(ready_o), 1);
    chk("mid_rst_start", int'(sr_start_o), 0);
    chk("mid_rst_x", int'(sr_x_bo), 0);
    chk("mid_rst_y", int'(y_bo), 0);
    chk("mid_rst_valid", int'(valid_o), 0);
    chk("mid_rst_err", int'(err_o), 0);
    xq.delete();
    yq.delete();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    rc = res_count;
    push_op(8'd64, 8'd8);
    wait_idle("post_rst");
    chk("post_rst_results", res_count - rc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
